// File: rtl/grover_phase_oracle_if.sv
// Valid/ready stream bundle for the Grover phase oracle: one amplitude stream in,
// one indexed amplitude stream out.
interface grover_phase_oracle_if #(
    parameter int NUM_BIT = 3,
    parameter int DATA_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [NUM_BIT-1:0] out_index;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/grover_phase_oracle.sv
// Streaming Grover phase oracle: buffers a frame of 2^NUM_BIT amplitudes, negates the marked
// index (or every masked index when GROVER_MULTI_TARGET_EN is defined), then replays the frame.
module grover_phase_oracle #(
    parameter int NUM_BIT = 3,
    parameter int DATA_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BIT-1:0]   target_search,
`ifdef GROVER_MULTI_TARGET_EN
    input  logic [2**NUM_BIT-1:0] target_mask,
`endif
    grover_phase_oracle_if.slave s,
    output logic                 busy
);
    localparam int NUM_SAMPLE = 2**NUM_BIT;
    localparam logic [NUM_BIT-1:0] LAST_IDX = NUM_BIT'(NUM_SAMPLE-1);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t             state, state_n;
    logic [NUM_BIT-1:0] wr_cnt, rd_cnt, rd_nxt;
    logic [DATA_W-1:0]  mem_q [NUM_SAMPLE];
    logic               in_ready_q, out_valid_q, out_last_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               in_fire, out_fire, hit;

    // Two's-complement negate that clamps the most negative code instead of wrapping.
    function automatic logic [DATA_W-1:0] neg_sat(input logic [DATA_W-1:0] x);
        if (x == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        return -x;
    endfunction

`ifdef GROVER_MULTI_TARGET_EN
    logic [NUM_SAMPLE-1:0] mask_q, mask_sel;
    always_comb begin
        mask_sel = (wr_cnt == '0) ? target_mask : mask_q;
        hit      = mask_sel[wr_cnt];
    end
`else
    logic [NUM_BIT-1:0] tgt_q, tgt_sel;
    always_comb begin
        tgt_sel = (wr_cnt == '0) ? target_search : tgt_q;
        hit     = (wr_cnt == tgt_sel);
    end
`endif

    assign in_fire     = s.in_valid & in_ready_q;
    assign out_fire    = out_valid_q & s.out_ready;
    assign rd_nxt      = rd_cnt + 1'b1;

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_index = rd_cnt;
    assign s.out_last  = out_last_q;

    always_comb begin
        state_n = state;
        case (state)
            LOAD: if (in_fire && wr_cnt == LAST_IDX) state_n = EMIT;
            EMIT: if (out_fire && out_last_q) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy        <= 1'b0;
`ifdef GROVER_MULTI_TARGET_EN
            mask_q      <= '0;
`else
            tgt_q       <= '0;
`endif
        end else begin
            in_ready_q <= (state_n == LOAD);
            if (in_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                busy   <= 1'b1;
`ifdef GROVER_MULTI_TARGET_EN
                if (wr_cnt == '0) mask_q <= target_mask;
`else
                if (wr_cnt == '0) tgt_q <= target_search;
`endif
            end
            // Entry 0 was written on an earlier beat, so it is already valid here.
            if (state == LOAD && state_n == EMIT) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem_q[0];
                out_last_q  <= 1'b0;
                rd_cnt      <= '0;
            end
            if (out_fire) begin
                if (out_last_q) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_last_q  <= 1'b0;
                    rd_cnt      <= '0;
                    busy        <= 1'b0;
                end else begin
                    rd_cnt     <= rd_nxt;
                    out_data_q <= mem_q[rd_nxt];
                    out_last_q <= (rd_nxt == LAST_IDX);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) mem_q[wr_cnt] <= hit ? neg_sat(s.in_data) : s.in_data;
    end
endmodule

// File: tb/tb_grover_phase_oracle.sv
// Directed bench for grover_phase_oracle: single/saturating/latched target, stalls, mid-frame reset,
// and the mask variant when GROVER_MULTI_TARGET_EN is defined.
module tb_grover_phase_oracle;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] target_search;
`ifdef GROVER_MULTI_TARGET_EN
    logic [7:0] target_mask;
    logic       use_mask;
    logic [7:0] mask_val;
`endif
    logic busy;

    grover_phase_oracle_if #(.NUM_BIT(3), .DATA_W(8)) ifc ();

    grover_phase_oracle #(.NUM_BIT(3), .DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .target_search(target_search),
`ifdef GROVER_MULTI_TARGET_EN
        .target_mask(target_mask),
`endif
        .s(ifc.slave),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [7:0] tx_data [8];
    logic signed [7:0] exp_d   [8];
    logic signed [7:0] got_data [8];
    logic [2:0]        got_index [8];
    logic              got_last [8];
    int                got_n;

    task automatic send_frame(input logic [2:0] tgt, input logic [2:0] alt, input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!ifc.in_ready && w < 50) begin
                @(posedge clk); #1; w++;
            end
            if (w >= 50) begin
                n_checks++;
                $display("FAIL send_timeout beat %0d: in_ready stuck low", k);
            end
            ifc.in_valid  = 1'b1;
            ifc.in_data   = tx_data[k];
            target_search = (k == 0) ? tgt : alt;
`ifdef GROVER_MULTI_TARGET_EN
            target_mask = use_mask ? mask_val : ((k == 0) ? (8'd1 << tgt) : (8'd1 << alt));
`endif
            if (k == 7) begin
                n_checks++;
                if (ifc.out_valid !== 1'b0) $display("FAIL early_valid: got %b want 0", ifc.out_valid);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1
    task automatic collect(input int mode);
        logic [3:0] pat = 4'b1001;
        logic       stalled = 1'b0;
        logic [7:0] snap_d = '0;
        logic [2:0] snap_i = '0;
        int cyc = 0;
        got_n = 0;
        while (got_n < 8 && cyc < 200) begin
            ifc.out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
            if (stalled) begin
                n_checks++;
                if (ifc.out_data !== snap_d || ifc.out_index !== snap_i)
                    $display("FAIL stall_hold: got data %0d idx %0d want data %0d idx %0d",
                             ifc.out_data, ifc.out_index, snap_d, snap_i);
                else n_pass++;
            end
            if (ifc.out_valid) begin
                n_checks++;
                if (ifc.in_ready !== 1'b0) $display("FAIL in_ready_emit: got %b want 0", ifc.in_ready);
                else n_pass++;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                got_data[got_n]  = ifc.out_data;
                got_index[got_n] = ifc.out_index;
                got_last[got_n]  = ifc.out_last;
                got_n++;
                stalled = 1'b0;
            end else if (ifc.out_valid) begin
                snap_d  = ifc.out_data;
                snap_i  = ifc.out_index;
                stalled = 1'b1;
            end
            @(posedge clk); #1; cyc++;
        end
        ifc.out_ready = 1'b0;
        n_checks++;
        if (got_n != 8) $display("FAIL collect_count: got %0d beats want 8", got_n);
        else n_pass++;
    endtask

    task automatic set_single_exp(input int tgt);
        for (int i = 0; i < 8; i++) exp_d[i] = (i == tgt) ? -tx_data[i] : tx_data[i];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_data !== 8'd0 ||
            ifc.out_index !== 3'd0 || ifc.out_last !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_vals: got rdy %b vld %b data %0d idx %0d last %b busy %b want all 0",
                     ifc.in_ready, ifc.out_valid, ifc.out_data, ifc.out_index, ifc.out_last, busy);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ifc.in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_reset: got rdy %b busy %b want 1 0", ifc.in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'sd32;
        set_single_exp(5);
        send_frame(3'd5, 3'd5, 8);
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_index !== 3'd0 || busy !== 1'b1)
            $display("FAIL basic_latency: got vld %b idx %0d busy %b want 1 0 1",
                     ifc.out_valid, ifc.out_index, busy);
        else n_pass++;
        collect(0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_data[i] !== exp_d[i] || got_index[i] !== 3'(i) || got_last[i] !== (i == 7))
                $display("FAIL basic[%0d]: got data %0d idx %0d last %b want %0d %0d %b",
                         i, got_data[i], got_index[i], got_last[i], exp_d[i], i, (i == 7));
            else n_pass++;
        end
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_done: got vld %b rdy %b busy %b want 0 1 0",
                     ifc.out_valid, ifc.in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'(i + 3);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy);
        else n_pass++;
        send_frame(3'd4, 3'd4, 1);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_beat0: got %b want 1", busy);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'sd10;
        tx_data[2] = -8'sd128;
        send_frame(3'd2, 3'd2, 8);
        collect(0);
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = (i == 2) ? 8'sd127 : 8'sd10;
            n_checks++;
            if (got_data[i] !== exp_d[i])
                $display("FAIL sat_min[%0d]: got %0d want %0d", i, got_data[i], exp_d[i]);
            else n_pass++;
        end
        tx_data[2] = 8'sd127;
        send_frame(3'd2, 3'd2, 8);
        collect(0);
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = (i == 2) ? -8'sd127 : 8'sd10;
            n_checks++;
            if (got_data[i] !== exp_d[i])
                $display("FAIL sat_max[%0d]: got %0d want %0d", i, got_data[i], exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_target_latch();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'(i * 10 + 1);
        set_single_exp(1);
        send_frame(3'd1, 3'd6, 8);
        collect(0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_data[i] !== exp_d[i])
                $display("FAIL tgt_latch[%0d]: got %0d want %0d", i, got_data[i], exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'(-(i + 1) * 5);
        set_single_exp(3);
        send_frame(3'd3, 3'd3, 8);
        collect(1);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_data[i] !== exp_d[i] || got_index[i] !== 3'(i) || got_last[i] !== (i == 7))
                $display("FAIL stall[%0d]: got data %0d idx %0d last %b want %0d %0d %b",
                         i, got_data[i], got_index[i], got_last[i], exp_d[i], i, (i == 7));
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'sd99;
        send_frame(3'd2, 3'd2, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || busy !== 1'b0 || ifc.out_index !== 3'd0)
            $display("FAIL midrst_vals: got rdy %b vld %b busy %b idx %0d want 0 0 0 0",
                     ifc.in_ready, ifc.out_valid, busy, ifc.out_index);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tx_data[i] = 8'(i + 1);
        set_single_exp(0);
        send_frame(3'd0, 3'd0, 8);
        collect(0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_data[i] !== exp_d[i] || got_index[i] !== 3'(i))
                $display("FAIL midrst[%0d]: got data %0d idx %0d want %0d %0d",
                         i, got_data[i], got_index[i], exp_d[i], i);
            else n_pass++;
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (ifc.out_valid !== 1'b0) $display("FAIL midrst_extra: got vld %b want 0", ifc.out_valid);
            else n_pass++;
        end
    endtask

`ifdef GROVER_MULTI_TARGET_EN
    task automatic test_multi();
        for (int i = 0; i < 8; i++) tx_data[i] = 8'sd16;
        use_mask = 1'b1;
        mask_val = 8'b1000_0011;
        send_frame(3'd4, 3'd4, 8);
        collect(0);
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = (i == 0 || i == 1 || i == 7) ? -8'sd16 : 8'sd16;
            n_checks++;
            if (got_data[i] !== exp_d[i])
                $display("FAIL multi[%0d]: got %0d want %0d", i, got_data[i], exp_d[i]);
            else n_pass++;
        end
        mask_val = 8'h00;
        send_frame(3'd4, 3'd4, 8);
        collect(0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_data[i] !== 8'sd16)
                $display("FAIL multi_zero[%0d]: got %0d want 16", i, got_data[i]);
            else n_pass++;
        end
        use_mask = 1'b0;
    endtask
`endif

    initial begin
        rst           = 1'b1;
        target_search = '0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
`ifdef GROVER_MULTI_TARGET_EN
        target_mask = '0;
        use_mask    = 1'b0;
        mask_val    = '0;
`endif
        test_reset();
        test_basic();
        test_busy_start();
        test_saturate();
        test_target_latch();
        test_stall();
        test_mid_reset();
`ifdef GROVER_MULTI_TARGET_EN
        test_multi();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/grover_phase_oracle.md
Name: grover_phase_oracle

Overview:
- Parametrised, streaming successor to the combinational Grover phase-inversion stage.
- Accepts one frame of 2^NUM_BIT signed fixed-point amplitudes over a valid/ready input stream and buffers the frame internally.
- Negates the amplitude at the target index, then replays the frame over a valid/ready output stream.
- Sits between the Hadamard/state-prep stage and the diffusion (inversion-about-mean) stage of the Grover iteration loop.

Parameters:
- NUM_BIT, 3, qubit count; frame length NUM_SAMPLE = 2**NUM_BIT (localparam, not overridable).
- DATA_W, 8, amplitude width, two's-complement signed fixed point.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- target_search  input  NUM_BIT  marked index; sampled on input beat 0 of each frame.
- in_valid  input  1  input amplitude valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  DATA_W  signed input amplitude; beat k carries basis index k.
- out_valid  output  1  output amplitude valid.
- out_ready  input  1  downstream accepts an output beat.
- out_data  output  DATA_W  signed output amplitude.
- out_index  output  NUM_BIT  basis index of the current out_data.
- out_last  output  1  high with the index NUM_SAMPLE-1 output beat.
- busy  output  1  high whenever a frame is partially loaded or being emitted.

Behaviour:
- Reset values: in_ready=0 during reset, then 1 on the first cycle after reset; out_valid=0, out_data=0, out_index=0, out_last=0, busy=0. Write and read counters clear to 0 and the FSM goes to LOAD.
- FSM states: LOAD and EMIT. The buffer is a NUM_SAMPLE x DATA_W register array.
- LOAD state:
  - in_ready=1, out_valid=0. A beat transfers on in_valid & in_ready.
  - On beat 0, target_search is latched into tgt_q. Later changes to target_search within the frame are ignored.
  - Beat k writes buf[k] = (k==tgt) ? neg(in_data) : in_data. For beat 0 the comparison uses the live target_search; afterwards it uses tgt_q.
  - busy=1 from the cycle after beat 0 is accepted.
  - When beat NUM_SAMPLE-1 is accepted, the FSM goes to EMIT on the next edge and the write counter wraps to 0.
- neg(x) is saturating: neg(-2^(DATA_W-1)) = 2^(DATA_W-1)-1; for all other values neg(x) = -x. Output width equals input width, with no growth.
- EMIT state:
  - in_ready=0. out_valid=1, out_data=buf[rd], out_index=rd, out_last=(rd==NUM_SAMPLE-1). All outputs are driven from registers.
  - A beat transfers on out_valid & out_ready and rd increments. While out_ready=0, all outputs hold stable.
  - After the out_last beat is accepted, the next edge sets out_valid=0, busy=0, in_ready=1, rd=0, and the FSM returns to LOAD.
- Latency: out_valid rises on the cycle after the final input beat is accepted. The first output beat appears 1 cycle after load completes, giving a minimum frame period of 2*NUM_SAMPLE cycles.
- There is no load/emit overlap: inputs are back-pressured for the whole of EMIT.
- Reset mid-frame (LOAD or EMIT): the partial frame is discarded, all outputs return to reset values, and no partial output frame continues after reset. Buffer contents are don't-care.
- in_valid held high continuously: exactly one beat per cycle is accepted in LOAD.

Optional Feature:
- Macro: GROVER_MULTI_TARGET_EN.
- When defined:
  - Adds input port target_mask [NUM_SAMPLE-1:0], sampled on beat 0 together with target_search.
  - Beat k is negated iff target_mask[k]=1; target_search is ignored.
  - An all-zero mask passes the frame through unchanged.
- When undefined: the target_mask port is absent and exactly the single index target_search is negated.

Test Plan:
- NUM_BIT=3, DATA_W=8. Load 8 beats of 32 with target_search=5 -> outputs 32,32,32,32,32,-32,32,32; out_last only on index 7; out_valid first high 1 cycle after the 8th input.
- Frame with index 2 = -128, target=2 -> out_data at index 2 = 127 (saturated). Second frame: index 2 = 127 -> -127.
- Change target_search from 1 to 6 after beat 0 (target=1 at beat 0) -> only index 1 negated.
- Toggle out_ready 1,0,0,1 in EMIT -> out_data/out_index held across stall cycles, no beat lost or duplicated; in_ready=0 throughout EMIT.
- Assert rst for 1 cycle after beat 4 of a load, then send a full frame with target=0 -> single clean 8-beat output with only index 0 negated.
- With GROVER_MULTI_TARGET_EN defined, target_mask=8'b1000_0011, all inputs 16 -> indices 0, 1 and 7 emit -16; all others emit 16.
